// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM (master) and the datapath / IR / memory side (slave).
interface multicycle_control_unit_if;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       pc_src_o;
  logic       ir_write_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       reg_write_o;
  logic [1:0] mem_to_reg_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       illegal_o;
  logic       mem_timeout_o;
  logic [3:0] state_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o, mem_timeout_o, state_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o, mem_timeout_o, state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multi-cycle RISC-V core with a memory handshake timeout.
// Optional feature: define JAL_EN to add the JAL state (opcode 1101111); otherwise JAL decodes as illegal.
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_LUI = 4'd5,
    S_ALU_WB   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } moore_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  function automatic moore_t decode_state(state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH: begin
        m.mem_read  = 1'b1;
        m.alu_src_b = 2'b01;
        m.alu_op    = 3'b110;
      end
      S_DECODE: begin
        m.alu_src_a = 2'b11;
        m.alu_src_b = 2'b10;
        m.alu_op    = 3'b110;
      end
      S_EXEC_R: begin
        m.alu_src_a = 2'b01;
        m.alu_src_b = 2'b00;
        m.alu_op    = 3'b000;
      end
      S_EXEC_I: begin
        m.alu_src_a = 2'b01;
        m.alu_src_b = 2'b10;
        m.alu_op    = 3'b001;
      end
      S_EXEC_LUI: begin
        m.alu_src_a = 2'b10;
        m.alu_src_b = 2'b10;
        m.alu_op    = 3'b100;
      end
      S_ALU_WB: m.reg_write = 1'b1;
      S_MEM_ADDR: begin
        m.alu_src_a = 2'b01;
        m.alu_src_b = 2'b10;
        m.alu_op    = 3'b110;
      end
      S_MEM_RD: begin
        m.mem_read = 1'b1;
        m.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        m.reg_write  = 1'b1;
        m.mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        m.mem_write = 1'b1;
        m.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        m.alu_src_a     = 2'b01;
        m.alu_src_b     = 2'b00;
        m.alu_op        = 3'b101;
        m.pc_write_cond = 1'b1;
        m.pc_src        = 1'b1;
      end
`ifdef JAL_EN
      S_JAL: begin
        m.reg_write  = 1'b1;
        m.mem_to_reg = 2'b10;
        m.pc_write   = 1'b1;
        m.pc_src     = 1'b1;
      end
`endif
      default: m = '0;
    endcase
    return m;
  endfunction

  state_t     state;
  state_t     state_nxt;
  moore_t     moore;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timed_out;
  logic       fetch_done;
  logic       legal_op;

  assign waiting    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timed_out  = waiting && !bus.mem_ready_i && (wait_cnt == WAIT_LAST);
  assign fetch_done = (state == S_FETCH) && bus.mem_ready_i;

  always_comb begin
    legal_op = 1'b0;
    case (bus.opcode_i)
      OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH: legal_op = 1'b1;
`ifdef JAL_EN
      OP_JAL: legal_op = 1'b1;
`endif
      default: legal_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode_i)
          OP_R:               state_nxt = S_EXEC_R;
          OP_I:               state_nxt = S_EXEC_I;
          OP_LUI:             state_nxt = S_EXEC_LUI;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
`ifdef JAL_EN
          OP_JAL:             state_nxt = S_JAL;
`endif
          default:            state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_nxt = S_ALU_WB;
      S_MEM_ADDR: state_nxt = (bus.opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready_i)  state_nxt = S_MEM_WB;
        else if (timed_out)   state_nxt = S_FETCH;
        else                  state_nxt = S_MEM_RD;
      end
      S_MEM_WR: state_nxt = (bus.mem_ready_i || timed_out) ? S_FETCH : S_MEM_WR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // A timeout back into FETCH counts as a fresh entry, so the counter restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RESET;
      moore    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      moore    <= decode_state(state_nxt);
      wait_cnt <= (waiting && (state_nxt == state) && !timed_out) ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  assign bus.pc_write_o      = fetch_done || moore.pc_write;
  assign bus.ir_write_o      = fetch_done;
  assign bus.pc_write_cond_o = moore.pc_write_cond;
  assign bus.pc_src_o        = moore.pc_src;
  assign bus.i_or_d_o        = moore.i_or_d;
  assign bus.mem_read_o      = moore.mem_read;
  assign bus.mem_write_o     = moore.mem_write;
  assign bus.reg_write_o     = moore.reg_write;
  assign bus.mem_to_reg_o    = moore.mem_to_reg;
  assign bus.alu_src_a_o     = moore.alu_src_a;
  assign bus.alu_src_b_o     = moore.alu_src_b;
  assign bus.alu_op_o        = moore.alu_op;
  assign bus.illegal_o       = (state == S_DECODE) && !legal_op;
  assign bus.mem_timeout_o   = timed_out;
  assign bus.state_o         = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: each instruction is expanded into its expected per-cycle control vectors.
module tb_multicycle_control_unit;

  localparam int T = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       timeout;
  } ctl_t;

  typedef enum int {
    P_FETCH, P_DEC, P_DEC_ILL, P_EXR, P_EXI, P_LUI, P_ALUWB,
    P_MADDR, P_MRD, P_MWB, P_MWR, P_BR, P_JAL
  } phase_e;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  ctl_t       exp_q[$];
  logic       rdy_q[$];
  logic [6:0] op_q[$];

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t s;
    s = {bus.pc_write_o, bus.pc_write_cond_o, bus.pc_src_o, bus.ir_write_o, bus.i_or_d_o,
         bus.mem_read_o, bus.mem_write_o, bus.reg_write_o, bus.mem_to_reg_o,
         bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.illegal_o, bus.mem_timeout_o};
    return s;
  endfunction

  // Control vector each phase must present; fr = fetch completing this cycle, to = timeout pulse.
  function automatic ctl_t exp_of(phase_e p, logic fr, logic to);
    ctl_t c;
    c = '0;
    case (p)
      P_FETCH: begin c.mem_read = 1; c.src_b = 2'b01; c.alu_op = 3'b110; c.ir_write = fr; c.pc_write = fr; end
      P_DEC:     begin c.src_a = 2'b11; c.src_b = 2'b10; c.alu_op = 3'b110; end
      P_DEC_ILL: begin c.src_a = 2'b11; c.src_b = 2'b10; c.alu_op = 3'b110; c.illegal = 1; end
      P_EXR:   begin c.src_a = 2'b01; c.src_b = 2'b00; c.alu_op = 3'b000; end
      P_EXI:   begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b001; end
      P_LUI:   begin c.src_a = 2'b10; c.src_b = 2'b10; c.alu_op = 3'b100; end
      P_ALUWB: begin c.reg_write = 1; c.mem_to_reg = 2'b00; end
      P_MADDR: begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b110; end
      P_MRD:   begin c.mem_read = 1; c.i_or_d = 1; end
      P_MWB:   begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      P_MWR:   begin c.mem_write = 1; c.i_or_d = 1; end
      P_BR:    begin c.src_a = 2'b01; c.alu_op = 3'b101; c.pc_write_cond = 1; c.pc_src = 1; end
      P_JAL:   begin c.reg_write = 1; c.mem_to_reg = 2'b10; c.pc_write = 1; c.pc_src = 1; end
      default: c = '0;
    endcase
    c.timeout = to;
    return c;
  endfunction

  task automatic push(phase_e p, logic fr, logic to, logic rdy, logic [6:0] op);
    exp_q.push_back(exp_of(p, fr, to));
    rdy_q.push_back(rdy);
    op_q.push_back(op);
  endtask

  // Non-memory phases get a random ready level: it must not matter there.
  task automatic push_plain(phase_e p, logic [6:0] op);
    push(p, 1'b0, 1'b0, 1'($urandom_range(0, 1)), op);
  endtask

  // A handshake phase with w not-ready cycles; w >= T aborts after T cycles with a timeout pulse.
  task automatic push_mem(phase_e p, int w, logic [6:0] op, output bit ok);
    logic [6:0] o;
    ok = 1'b0;
    for (int i = 0; i < w && i < T; i++) begin
      o = (p == P_FETCH) ? 7'($urandom) : op;
      push(p, 1'b0, (i == T - 1), 1'b0, o);
    end
    if (w < T) begin
      o = (p == P_FETCH) ? 7'($urandom) : op;
      push(p, 1'b1, 1'b0, 1'b1, o);
      ok = 1'b1;
    end
  endtask

  task automatic build_seq(logic [6:0] op, int wf, int wm);
    bit ok;
    push_mem(P_FETCH, wf, op, ok);
    if (!ok) return;
    case (op)
      OP_R:      begin push_plain(P_DEC, op); push_plain(P_EXR, op); push_plain(P_ALUWB, op); end
      OP_I:      begin push_plain(P_DEC, op); push_plain(P_EXI, op); push_plain(P_ALUWB, op); end
      OP_LUI:    begin push_plain(P_DEC, op); push_plain(P_LUI, op); push_plain(P_ALUWB, op); end
      OP_LOAD: begin
        push_plain(P_DEC, op); push_plain(P_MADDR, op);
        push_mem(P_MRD, wm, op, ok);
        if (ok) push_plain(P_MWB, op);
      end
      OP_STORE: begin
        push_plain(P_DEC, op); push_plain(P_MADDR, op);
        push_mem(P_MWR, wm, op, ok);
      end
      OP_BRANCH: begin push_plain(P_DEC, op); push_plain(P_BR, op); end
`ifdef JAL_EN
      OP_JAL:    begin push_plain(P_DEC, op); push_plain(P_JAL, op); end
`endif
      default:   push_plain(P_DEC_ILL, op);
    endcase
  endtask

  task automatic cycle(input logic rdy, input logic [6:0] op, output ctl_t obs);
    @(posedge clk);
    #1;
    bus.mem_ready_i = rdy;
    bus.opcode_i    = op;
    @(negedge clk);
    obs = sample();
  endtask

  task automatic test_reset();
    ctl_t obs, e;
    reset = 1'b0;
    bus.mem_ready_i = 1'b1;
    bus.opcode_i    = 7'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (sample() !== ctl_t'(0)) begin n_fail++; $display("FAIL reset_outputs cyc %0d: got %h want 0", k, sample()); end
      n_checks++;
      if (bus.state_o !== 4'd0) begin n_fail++; $display("FAIL reset_state cyc %0d: got %0d want 0", k, bus.state_o); end
    end
    #1 reset = 1'b1;
    cycle(1'b1, OP_BAD, obs);
    e = exp_of(P_FETCH, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL first_fetch: got %h want %h", obs, e); end
    n_checks++;
    if (bus.state_o === 4'd0) begin n_fail++; $display("FAIL first_fetch_state: got %0d want nonzero", bus.state_o); end
    push_plain(P_DEC_ILL, OP_BAD);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL post_reset cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_alu();
    ctl_t obs, e;
    build_seq(OP_R, 0, 0);
    build_seq(OP_I, 0, 0);
    build_seq(OP_LUI, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL alu_seq cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_lw_wait();
    ctl_t obs, e;
    build_seq(OP_LOAD, 0, 3);
    build_seq(OP_STORE, 2, 0);
    build_seq(OP_LOAD, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL mem_wait cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_timeout();
    ctl_t obs, e;
    build_seq(OP_STORE, 0, 50);
    build_seq(OP_LOAD, 0, T + 1);
    build_seq(OP_R, 9, 0);
    build_seq(OP_R, T - 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL timeout cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_illegal_branch();
    ctl_t obs, e;
    build_seq(OP_BAD, 0, 0);
    build_seq(OP_BRANCH, 0, 0);
    build_seq(OP_JAL, 0, 0);
    build_seq(7'b0000000, 1, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL illegal_branch cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_random();
    ctl_t obs, e;
    logic [6:0] ops [8];
    logic [6:0] op;
    ops = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_BAD};
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      build_seq(op, ($urandom_range(0, 5) == 0) ? $urandom_range(0, T + 1) : $urandom_range(0, 1),
                $urandom_range(0, T + 1));
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    ctl_t obs, e;
    build_seq(OP_STORE, 0, 50);
    for (int k = 0; k < 4; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL pre_abort cyc %0d: got %h want %h", k, obs, e); end
    end
    exp_q.delete(); rdy_q.delete(); op_q.delete();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_write_o !== 1'b0) begin n_fail++; $display("FAIL abort_mem_write: got %b want 0", bus.mem_write_o); end
    n_checks++;
    if (bus.state_o !== 4'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", bus.state_o); end
    n_checks++;
    if (sample() !== ctl_t'(0)) begin n_fail++; $display("FAIL abort_outputs: got %h want 0", sample()); end
    @(negedge clk);
    n_checks++;
    if (sample() !== ctl_t'(0)) begin n_fail++; $display("FAIL abort_hold: got %h want 0", sample()); end
    #1 reset = 1'b1;
    build_seq(OP_R, 0, 0);
    build_seq(OP_JAL, 0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      cycle(rdy_q.pop_front(), op_q.pop_front(), obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL post_abort cyc %0d: got %h want %h", k, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_timeout();
    test_illegal_branch();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
